// File: rtl/steak_pkg.sv
// Shared types and grading constants for the steak grill tracker.
package steak_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COOK_A = 3'd1,
    COOK_B = 3'd2,
    BURNT  = 3'd3
  } state_e;

  localparam logic [4:0] PTS_RAW    = 5'd0;
  localparam logic [4:0] PTS_COOKED = 5'd5;
  localparam logic [4:0] PTS_DONE   = 5'd10;

endpackage

// File: rtl/steak_side_timer.sv
// Saturating seconds counter for one side of the steak, with its grade and
// a look-ahead burn compare on the value it is about to take.
module steak_side_timer
  import steak_pkg::*;
#(
  parameter int TIME_W = 6,
  parameter int RARE_T = 5,
  parameter int DONE_T = 8,
  parameter int BURN_T = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [TIME_W-1:0] time_o,
  output logic [4:0]        pts_o,
  output logic              burn_o
);

  localparam logic [TIME_W-1:0] RARE_V = RARE_T[TIME_W-1:0];
  localparam logic [TIME_W-1:0] DONE_V = DONE_T[TIME_W-1:0];
  localparam logic [TIME_W-1:0] BURN_V = BURN_T[TIME_W-1:0];

  logic [TIME_W-1:0] time_q;
  logic [TIME_W-1:0] time_d;

  always_comb begin
    time_d = time_q;
    if (clear_i) begin
      time_d = '0;
    end else if (inc_i && (time_q != '1)) begin
      time_d = time_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q <= '0;
    end else begin
      time_q <= time_d;
    end
  end

  // Burn is judged on the post-increment value so the FSM can leave on the same edge.
  assign burn_o = (time_d >= BURN_V);

  always_comb begin
    pts_o = PTS_RAW;
    if (time_q >= DONE_V) begin
      pts_o = PTS_DONE;
    end else if (time_q >= RARE_V) begin
      pts_o = PTS_COOKED;
    end
  end

  assign time_o = time_q;

endmodule

// File: rtl/steak_grill_tracker.sv
// Tracks one steak through place/cook/flip/serve/burn and keeps a running score.
// Optional STEAK_FLIP_PENALTY_EN deducts points for excessive flipping.
module steak_grill_tracker
  import steak_pkg::*;
#(
  parameter int TIME_W  = 6,
  parameter int RARE_T  = 5,
  parameter int DONE_T  = 8,
  parameter int BURN_T  = 12,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               place,
  input  logic               flip,
  input  logic               serve,
  output logic [2:0]         state,
  output logic [TIME_W-1:0]  time_a,
  output logic [TIME_W-1:0]  time_b,
  output logic               burnt,
  output logic               serve_valid,
  output logic [SCORE_W-1:0] serve_score,
  output logic [SCORE_W-1:0] total_score
);

  state_e             state_q;
  logic               serveValid_q;
  logic [SCORE_W-1:0] serveScore_q;
  logic [SCORE_W-1:0] totalScore_q;
  logic [SCORE_W-1:0] serveScore_d;
  logic [SCORE_W-1:0] totalScore_d;
  logic [SCORE_W:0]   totalSum;
  logic [SCORE_W-1:0] baseScore;

  logic       clearSides;
  logic       incA;
  logic       incB;
  logic       burnA;
  logic       burnB;
  logic       burnNow;
  logic       cooking;
  logic [4:0] ptsA;
  logic [4:0] ptsB;

  assign cooking    = (state_q == COOK_A) || (state_q == COOK_B);
  assign clearSides = (state_q == IDLE) && place;
  // A serve in the same cycle swallows the tick.
  assign incA       = (state_q == COOK_A) && tick && !serve;
  assign incB       = (state_q == COOK_B) && tick && !serve;
  assign burnNow    = (incA && burnA) || (incB && burnB);

  steak_side_timer #(
    .TIME_W(TIME_W), .RARE_T(RARE_T), .DONE_T(DONE_T), .BURN_T(BURN_T)
  ) u_side_a (
    .clk(clk), .reset(reset), .clear_i(clearSides), .inc_i(incA),
    .time_o(time_a), .pts_o(ptsA), .burn_o(burnA)
  );

  steak_side_timer #(
    .TIME_W(TIME_W), .RARE_T(RARE_T), .DONE_T(DONE_T), .BURN_T(BURN_T)
  ) u_side_b (
    .clk(clk), .reset(reset), .clear_i(clearSides), .inc_i(incB),
    .time_o(time_b), .pts_o(ptsB), .burn_o(burnB)
  );

  assign baseScore = {{(SCORE_W-5){1'b0}}, ptsA} + {{(SCORE_W-5){1'b0}}, ptsB};

`ifdef STEAK_FLIP_PENALTY_EN
  logic [3:0]         flips_q;
  logic [SCORE_W-1:0] penalty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flips_q <= '0;
    end else if (clearSides) begin
      flips_q <= '0;
    end else if (cooking && flip && !serve && (flips_q != 4'hF)) begin
      flips_q <= flips_q + 4'd1;
    end
  end

  // The first flip is free; every further flip costs one point, floored at zero.
  assign penalty      = (flips_q > 4'd1) ? {{(SCORE_W-4){1'b0}}, flips_q - 4'd1} : '0;
  assign serveScore_d = (baseScore > penalty) ? (baseScore - penalty) : '0;
`else
  assign serveScore_d = baseScore;
`endif

  assign totalSum     = {1'b0, totalScore_q} + {1'b0, serveScore_q};
  assign totalScore_d = totalSum[SCORE_W] ? '1 : totalSum[SCORE_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      serveValid_q <= 1'b0;
      serveScore_q <= '0;
      totalScore_q <= '0;
    end else begin
      serveValid_q <= 1'b0;
      if (serveValid_q) begin
        totalScore_q <= totalScore_d;
      end
      case (state_q)
        IDLE: begin
          if (place) state_q <= COOK_A;
        end
        COOK_A, COOK_B: begin
          if (serve) begin
            serveValid_q <= 1'b1;
            serveScore_q <= serveScore_d;
            state_q      <= IDLE;
          end else if (burnNow) begin
            state_q <= BURNT;
          end else if (flip) begin
            state_q <= (state_q == COOK_A) ? COOK_B : COOK_A;
          end
        end
        BURNT: begin
          if (serve) begin
            serveValid_q <= 1'b1;
            serveScore_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign burnt       = (state_q == BURNT);
  assign serve_valid = serveValid_q;
  assign serve_score = serveScore_q;
  assign total_score = totalScore_q;

endmodule
